// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, runs the i-mem request/ready
// handshake and keeps up to two fetched instructions queued ahead of ID.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        i_mem_req_o,
  output logic [31:0] i_mem_addr_o,
  input  logic        i_mem_ready_i,
  input  logic [31:0] i_mem_rdata_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc_plus_4_o
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CNTW = 2;

  typedef enum logic [1:0] {RUN, REQ, DROP} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
  } entry_t;

  localparam entry_t ENTRY_RST = '{pc: '0, pc4: XLEN'(4), instr: '0};

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic [CNTW-1:0] count_q;
  entry_t          head_q;
  entry_t          tail_q;

  logic            pop;
  logic            push;
  logic            space;
  logic [CNTW-1:0] count_after_pop;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_inc;
  entry_t          new_entry;

  assign pop             = if_id_valid_o & ~id_stall_i;
  assign push            = (state_q == REQ) & i_mem_ready_i & ~redirect_i;
  assign count_after_pop = count_q - CNTW'(pop);
  assign space           = count_after_pop < CNTW'(2);
  assign target          = redirect_pc_i & ~XLEN'(3);
  assign pc_inc          = pc_q + XLEN'(4);
  assign new_entry       = '{pc: pc_q, pc4: pc_inc, instr: i_mem_rdata_i};

  assign if_id_instr_o     = head_q.instr;
  assign if_id_pc_o        = head_q.pc;
  assign if_id_pc_plus_4_o = head_q.pc4;

  // Two-entry in-order buffer; head_q feeds ID directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q       <= '0;
      if_id_valid_o <= 1'b0;
      head_q        <= ENTRY_RST;
      tail_q        <= ENTRY_RST;
    end else if (redirect_i) begin
      count_q       <= '0;
      if_id_valid_o <= 1'b0;
    end else begin
      if (push && count_after_pop == CNTW'(0)) begin
        head_q <= new_entry;
      end else if (pop) begin
        head_q <= tail_q;
      end
      if (push && count_after_pop == CNTW'(1)) begin
        tail_q <= new_entry;
      end
      count_q       <= count_after_pop + CNTW'(push);
      if_id_valid_o <= (count_after_pop != CNTW'(0)) | push;
    end
  end

  // Fetch FSM; the address register only moves once the current request is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      i_mem_req_o  <= 1'b0;
      i_mem_addr_o <= RESET_PC;
    end else begin
      case (state_q)
        RUN: begin
          if (redirect_i) begin
            pc_q         <= target;
            state_q      <= REQ;
            i_mem_req_o  <= 1'b1;
            i_mem_addr_o <= target;
          end else if (space) begin
            state_q      <= REQ;
            i_mem_req_o  <= 1'b1;
            i_mem_addr_o <= pc_q;
          end
        end
        REQ: begin
          if (i_mem_ready_i) begin
            if (redirect_i) begin
              pc_q         <= target;
              i_mem_addr_o <= target;
            end else begin
              pc_q         <= pc_inc;
              i_mem_addr_o <= pc_inc;
              if (count_after_pop != CNTW'(0)) begin
                state_q     <= RUN;
                i_mem_req_o <= 1'b0;
              end
            end
          end else if (redirect_i) begin
            pc_q    <= target;
            state_q <= DROP;
          end
        end
        DROP: begin
          if (redirect_i) begin
            pc_q <= target;
          end
          if (i_mem_ready_i) begin
            state_q      <= REQ;
            i_mem_addr_o <= redirect_i ? target : pc_q;
          end
        end
        default: begin
          state_q     <= RUN;
          i_mem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: expected fetches queued as memory accepts them,
// compared in order as ID consumes the head entry.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_B = 32'hFFFF_FFF8;
  localparam logic [31:0] JUNK  = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ready;

  logic        req_a, valid_a, req_b, valid_b;
  logic [31:0] addr_a, rdata_a, instr_a, pc_a, pc4_a;
  logic [31:0] addr_b, rdata_b, instr_b, pc_b, pc4_b;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign rdata_a = mem_word(addr_a);
  assign rdata_b = mem_word(addr_b);

  fetch_ctrl dut_a (
    .clk(clk), .rst(rst), .id_stall_i(id_stall), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .i_mem_req_o(req_a), .i_mem_addr_o(addr_a),
    .i_mem_ready_i(ready), .i_mem_rdata_i(rdata_a), .if_id_valid_o(valid_a),
    .if_id_instr_o(instr_a), .if_id_pc_o(pc_a), .if_id_pc_plus_4_o(pc4_a)
  );

  fetch_ctrl #(.RESET_PC(RST_B)) dut_b (
    .clk(clk), .rst(rst), .id_stall_i(id_stall), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .i_mem_req_o(req_b), .i_mem_addr_o(addr_b),
    .i_mem_ready_i(ready), .i_mem_rdata_i(rdata_b), .if_id_valid_o(valid_b),
    .if_id_instr_o(instr_b), .if_id_pc_o(pc_b), .if_id_pc_plus_4_o(pc4_b)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ready = 1'b0; id_stall = 1'b0; redirect = 1'b0; redirect_pc = JUNK;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; ready = 1'b1; id_stall = 1'b0; redirect = 1'b0; redirect_pc = JUNK;
    repeat (2) @(negedge clk);
    vectors++;
    if ({req_a, addr_a, valid_a, instr_a, pc_a, pc4_a} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h4}) begin
      miscompares++;
      $display("FAIL reset_a: req=%b addr=%h valid=%b instr=%h pc=%h pc4=%h, want 0/0/0/0/0/4",
               req_a, addr_a, valid_a, instr_a, pc_a, pc4_a);
    end
    vectors++;
    if ({req_b, addr_b, valid_b, pc4_b} !== {1'b0, RST_B, 1'b0, 32'h4}) begin
      miscompares++;
      $display("FAIL reset_b: req=%b addr=%h valid=%b pc4=%h, want 0/%h/0/4", req_b, addr_b, valid_b, pc4_b, RST_B);
    end
  endtask

  task automatic test_stream();
    exp_t e; logic [31:0] ea; logic ev;
    do_reset();
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      ready = 1'b1; id_stall = 1'b0; redirect = 1'b0;
      ea = 32'(4 * (j - 1)); ev = (j >= 2);
      vectors++;
      if ({req_a, addr_a, valid_a} !== {1'b1, ea, ev}) begin
        miscompares++;
        $display("FAIL stream_if j=%0d: req=%b addr=%h valid=%b, want 1/%h/%b", j, req_a, addr_a, valid_a, ea, ev);
      end
      if (valid_a && !id_stall) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++; $display("FAIL stream_deliver: extra pc=%h, want none", pc_a);
        end else begin
          e = sb.pop_front();
          if ({pc_a, instr_a, pc4_a} !== {e.pc, e.instr, e.pc + 32'd4}) begin
            miscompares++;
            $display("FAIL stream_deliver: pc=%h instr=%h pc4=%h, want %h/%h/%h", pc_a, instr_a, pc4_a, e.pc, e.instr, e.pc + 32'd4);
          end
        end
      end
      sb.push_back('{pc: ea, instr: mem_word(ea)});
    end
    vectors++;
    if (sb.size() != 1) begin
      miscompares++; $display("FAIL stream_left: %0d queued, want 1", sb.size());
    end
  endtask

  task automatic test_stall();
    exp_t e; logic [31:0] ea; logic er;
    do_reset();
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      ready = 1'b1; redirect = 1'b0;
      id_stall = (j >= 4 && j <= 6);
      er = !(j >= 5 && j <= 7);
      ea = (j <= 4) ? 32'(4 * (j - 1)) : (j <= 7) ? 32'h10 : 32'(16 + 4 * (j - 8));
      vectors++;
      if ({req_a, addr_a, valid_a} !== {er, ea, j >= 2}) begin
        miscompares++;
        $display("FAIL stall_if j=%0d: req=%b addr=%h valid=%b, want %b/%h/%b", j, req_a, addr_a, valid_a, er, ea, j >= 2);
      end
      if (j >= 4 && j <= 7) begin
        vectors++;
        if (pc_a !== 32'h8) begin
          miscompares++; $display("FAIL stall_head j=%0d: pc=%h, want 00000008", j, pc_a);
        end
      end
      if (valid_a && !id_stall) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++; $display("FAIL stall_deliver: extra pc=%h, want none", pc_a);
        end else begin
          e = sb.pop_front();
          if ({pc_a, instr_a, pc4_a} !== {e.pc, e.instr, e.pc + 32'd4}) begin
            miscompares++;
            $display("FAIL stall_deliver: pc=%h instr=%h pc4=%h, want %h/%h/%h", pc_a, instr_a, pc4_a, e.pc, e.instr, e.pc + 32'd4);
          end
        end
      end
      if (er) sb.push_back('{pc: ea, instr: mem_word(ea)});
    end
    vectors++;
    if (sb.size() != 1) begin
      miscompares++; $display("FAIL stall_left: %0d queued, want 1", sb.size());
    end
  endtask

  task automatic test_wait();
    exp_t e; logic [31:0] ea; logic ev;
    do_reset();
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      id_stall = 1'b0; redirect = 1'b0;
      ready = !(j == 5 || j == 6);
      ea = (j <= 5) ? 32'(4 * (j - 1)) : (j <= 7) ? 32'h10 : 32'(16 + 4 * (j - 7));
      ev = (j >= 2) && !(j == 6 || j == 7);
      vectors++;
      if ({req_a, addr_a, valid_a} !== {1'b1, ea, ev}) begin
        miscompares++;
        $display("FAIL wait_if j=%0d: req=%b addr=%h valid=%b, want 1/%h/%b", j, req_a, addr_a, valid_a, ea, ev);
      end
      if (valid_a && !id_stall) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++; $display("FAIL wait_deliver: extra pc=%h, want none", pc_a);
        end else begin
          e = sb.pop_front();
          if ({pc_a, instr_a, pc4_a} !== {e.pc, e.instr, e.pc + 32'd4}) begin
            miscompares++;
            $display("FAIL wait_deliver: pc=%h instr=%h pc4=%h, want %h/%h/%h", pc_a, instr_a, pc4_a, e.pc, e.instr, e.pc + 32'd4);
          end
        end
      end
      if (ready) sb.push_back('{pc: ea, instr: mem_word(ea)});
    end
    vectors++;
    if (sb.size() != 1) begin
      miscompares++; $display("FAIL wait_left: %0d queued, want 1", sb.size());
    end
  endtask

  task automatic test_redirect_drop();
    exp_t e; logic [31:0] ea; logic ev; logic dropping;
    do_reset();
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      id_stall = 1'b0;
      ready = !(j >= 9 && j <= 11);
      redirect = (j == 9);
      redirect_pc = (j == 9) ? 32'h100 : JUNK;
      dropping = (j >= 10 && j <= 12);
      ea = (j <= 9) ? 32'(4 * (j - 1)) : dropping ? 32'h20 : 32'(256 + 4 * (j - 13));
      ev = (j >= 2 && j <= 9) || (j >= 14);
      vectors++;
      if ({req_a, addr_a, valid_a} !== {1'b1, ea, ev}) begin
        miscompares++;
        $display("FAIL drop_if j=%0d: req=%b addr=%h valid=%b, want 1/%h/%b", j, req_a, addr_a, valid_a, ea, ev);
      end
      if (valid_a && !id_stall) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++; $display("FAIL drop_deliver: extra pc=%h, want none", pc_a);
        end else begin
          e = sb.pop_front();
          if ({pc_a, instr_a, pc4_a} !== {e.pc, e.instr, e.pc + 32'd4}) begin
            miscompares++;
            $display("FAIL drop_deliver: pc=%h instr=%h pc4=%h, want %h/%h/%h", pc_a, instr_a, pc4_a, e.pc, e.instr, e.pc + 32'd4);
          end
        end
      end
      if (redirect) sb.delete();
      else if (ready && !dropping) sb.push_back('{pc: ea, instr: mem_word(ea)});
    end
    redirect = 1'b0;
    vectors++;
    if (sb.size() != 1) begin
      miscompares++; $display("FAIL drop_left: %0d queued, want 1", sb.size());
    end
  endtask

  task automatic test_redirect_ready();
    exp_t e; logic [31:0] ea; logic ev;
    do_reset();
    for (int j = 1; j <= 21; j++) begin
      @(negedge clk);
      id_stall = 1'b0; ready = 1'b1;
      redirect = (j == 17);
      redirect_pc = (j == 17) ? 32'h102 : JUNK;
      ea = (j <= 17) ? 32'(4 * (j - 1)) : 32'(256 + 4 * (j - 18));
      ev = (j >= 2 && j <= 17) || (j >= 19);
      vectors++;
      if ({req_a, addr_a, valid_a} !== {1'b1, ea, ev}) begin
        miscompares++;
        $display("FAIL redir_if j=%0d: req=%b addr=%h valid=%b, want 1/%h/%b", j, req_a, addr_a, valid_a, ea, ev);
      end
      if (valid_a && !id_stall) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++; $display("FAIL redir_deliver: extra pc=%h, want none", pc_a);
        end else begin
          e = sb.pop_front();
          if ({pc_a, instr_a, pc4_a} !== {e.pc, e.instr, e.pc + 32'd4}) begin
            miscompares++;
            $display("FAIL redir_deliver: pc=%h instr=%h pc4=%h, want %h/%h/%h", pc_a, instr_a, pc4_a, e.pc, e.instr, e.pc + 32'd4);
          end
        end
      end
      if (redirect) sb.delete();
      else sb.push_back('{pc: ea, instr: mem_word(ea)});
    end
    redirect = 1'b0;
    vectors++;
    if (sb.size() != 1) begin
      miscompares++; $display("FAIL redir_left: %0d queued, want 1", sb.size());
    end
  endtask

  task automatic test_wrap_reset();
    exp_t e; logic [31:0] ea; logic ev;
    do_reset();
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      id_stall = 1'b0; redirect = 1'b0;
      ready = (j <= 4);
      ea = (j <= 5) ? RST_B + 32'(4 * (j - 1)) : RST_B + 32'd16;
      ev = (j >= 2 && j <= 5);
      vectors++;
      if ({req_b, addr_b, valid_b} !== {1'b1, ea, ev}) begin
        miscompares++;
        $display("FAIL wrap_if j=%0d: req=%b addr=%h valid=%b, want 1/%h/%b", j, req_b, addr_b, valid_b, ea, ev);
      end
      if (valid_b && !id_stall) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++; $display("FAIL wrap_deliver: extra pc=%h, want none", pc_b);
        end else begin
          e = sb.pop_front();
          if ({pc_b, instr_b, pc4_b} !== {e.pc, e.instr, e.pc + 32'd4}) begin
            miscompares++;
            $display("FAIL wrap_deliver: pc=%h instr=%h pc4=%h, want %h/%h/%h", pc_b, instr_b, pc4_b, e.pc, e.instr, e.pc + 32'd4);
          end
        end
      end
      if (ready) sb.push_back('{pc: ea, instr: mem_word(ea)});
      if (j == 6) rst = 1'b1;
    end
    @(negedge clk);
    vectors++;
    if ({req_b, addr_b, valid_b, instr_b, pc_b, pc4_b} !== {1'b0, RST_B, 1'b0, 32'h0, 32'h0, 32'h4}) begin
      miscompares++;
      $display("FAIL wrap_rst: req=%b addr=%h valid=%b instr=%h pc=%h pc4=%h, want 0/%h/0/0/0/4",
               req_b, addr_b, valid_b, instr_b, pc_b, pc4_b, RST_B);
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL wrap_left: %0d queued, want 0", sb.size());
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ready = 1'b0; id_stall = 1'b0; redirect = 1'b0; redirect_pc = JUNK;
    test_reset();
    test_stream();
    test_stall();
    test_wait();
    test_redirect_drop();
    test_redirect_ready();
    test_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
